// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and
// load unit, with a per-register pending-write scoreboard for RAW hazard detection.
module reg_write_arbiter #(
    parameter int NUM_REG = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_ready_o,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic              hazard_o,
    output logic              rf_write_o,
    output logic [ADDR_W-1:0] rf_rd_o,
    output logic [DATA_W-1:0] rf_writedata_o,
    output logic [15:0]       conflict_count_o
);

    localparam logic WIN_ALU = 1'b0;
    localparam logic WIN_MEM = 1'b1;
    localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

    logic               grant_alu_s;
    logic               grant_mem_s;
    logic               conflict_s;
    logic               last_win_q,   last_win_d;
    logic               rf_write_q,   rf_write_d;
    logic [ADDR_W-1:0]  rf_rd_q,      rf_rd_d;
    logic [DATA_W-1:0]  rf_data_q,    rf_data_d;
    logic [NUM_REG-1:0] busy_q,       busy_d;
    logic [15:0]        conflict_q,   conflict_d;

    // Arbitration; grants are suppressed while reset is held
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        conflict_s  = 1'b0;
        if (!rst_ni) begin
            grant_alu_s = 1'b0;
            grant_mem_s = 1'b0;
        end else if (alu_valid_i && mem_valid_i) begin
            conflict_s = 1'b1;
            if (last_win_q == WIN_MEM) begin
                grant_alu_s = 1'b1;
            end else begin
                grant_mem_s = 1'b1;
            end
        end else if (alu_valid_i) begin
            grant_alu_s = 1'b1;
        end else if (mem_valid_i) begin
            grant_mem_s = 1'b1;
        end else begin
            grant_alu_s = 1'b0;
        end
    end

    // Round-robin pointer moves only on conflict cycles
    always_comb begin
        last_win_d = last_win_q;
        if (conflict_s) begin
            last_win_d = grant_mem_s ? WIN_MEM : WIN_ALU;
        end else begin
            last_win_d = last_win_q;
        end
    end

    // Write-port register next state; r0 targets are accepted but never written
    always_comb begin
        rf_write_d = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        if (grant_alu_s) begin
            rf_write_d = (alu_rd_i != REG_ZERO);
            rf_rd_d    = alu_rd_i;
            rf_data_d  = alu_data_i;
        end else if (grant_mem_s) begin
            rf_write_d = (mem_rd_i != REG_ZERO);
            rf_rd_d    = mem_rd_i;
            rf_data_d  = mem_data_i;
        end else begin
            rf_write_d = 1'b0;
        end
    end

    // Scoreboard: clear on RF write, then set on issue so a newer producer wins
    always_comb begin
        busy_d = busy_q;
        if (rf_write_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (issue_valid_i && (issue_rd_i != REG_ZERO)) begin
            busy_d[issue_rd_i] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Saturating count of conflict cycles
    always_comb begin
        conflict_d = conflict_q;
        if (conflict_s && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_win_q <= WIN_MEM;
            rf_write_q <= 1'b0;
            rf_rd_q    <= {ADDR_W{1'b0}};
            rf_data_q  <= {DATA_W{1'b0}};
            busy_q     <= {NUM_REG{1'b0}};
            conflict_q <= 16'd0;
        end else begin
            last_win_q <= last_win_d;
            rf_write_q <= rf_write_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign alu_ready_o      = grant_alu_s;
    assign mem_ready_o      = grant_mem_s;
    assign hazard_o         = ((rs1_i != REG_ZERO) && busy_q[rs1_i]) ||
                              ((rs2_i != REG_ZERO) && busy_q[rs2_i]);
    assign rf_write_o       = rf_write_q;
    assign rf_rd_o          = rf_rd_q;
    assign rf_writedata_o   = rf_data_q;
    assign conflict_count_o = conflict_q;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port between the two writeback producers, the ALU and the memory load unit. It uses round-robin arbitration and valid/ready handshakes. A per-register pending (busy) scoreboard lets the issue stage detect read-after-write hazards on rs1/rs2. The block sits between the execute/memory stages and the register file's `write`/`rd`/`writedata` inputs, and drives those inputs from registers.

## Interface
- NUM_REG, 16, number of architectural registers; register 0 is hardwired zero
- ADDR_W, 4, register address width
- DATA_W, 16, data width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- mem_valid  in  1  load writeback request
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle (combinational)
- issue_valid  in  1  instruction issued this cycle that will write issue_rd
- issue_rd  in  ADDR_W  destination register of the issued instruction
- rs1, rs2  in  ADDR_W  source registers of the instruction at issue
- hazard  out  1  rs1 or rs2 has a pending write (combinational)
- rf_write  out  1  register file write enable (registered)
- rf_rd  out  ADDR_W  register file write address (registered)
- rf_writedata  out  DATA_W  register file write data (registered)
- conflict_count  out  16  number of cycles in which both requesters were valid; saturates at 16'hFFFF

## Operation
- **Requester rule.** A requester holds valid, rd and data stable until it sees its ready. An accepted request is consumed on that clock edge.
- **Arbitration.** At most one grant per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted at the last conflict wins.
  - A 1-bit `last_conflict_winner` is updated only on conflict cycles. Its reset value is MEM, so the ALU wins the first conflict.
- **Ready outputs.** alu_ready = grant_alu; mem_ready = grant_mem. Neither depends on downstream state; the arbiter never back-pressures a lone requester.
- **Write register.** On a grant, rf_rd and rf_writedata load the winner's rd and data.
  - rf_write loads 1 only if the winner's rd ≠ 0. Writes to r0 are accepted and silently dropped.
  - With no grant, rf_write loads 0 and rf_rd/rf_writedata hold their values.
- **Scoreboard.** `busy[NUM_REG-1:0]`.
  - Set: issue_valid && issue_rd ≠ 0 sets busy[issue_rd] at the edge.
  - Clear: rf_write == 1 clears busy[rf_rd] at the edge, i.e. at the end of the cycle in which the register file is written.
  - Same register set and cleared on the same edge: set wins, because a newer producer exists.
  - busy[0] is always 0.
- **Hazard.** hazard = (rs1 ≠ 0 && busy[rs1]) || (rs2 ≠ 0 && busy[rs2]).
- **Conflict counter.** Increments on every cycle with alu_valid && mem_valid. Holds at 16'hFFFF once saturated.

## Timing
- Grant to register file write: 1 cycle. A request granted in cycle N produces rf_write/rf_rd/rf_writedata in cycle N+1.
- Scoreboard latency: issue in cycle N → busy visible, and hazard asserted, in cycle N+1. A write presented to the register file in cycle M clears busy, and hazard drops, in cycle M+1.
- Throughput: one write per cycle. Two requesters both continuously valid alternate grants every cycle.
- Reset (reset = 0, asynchronous) forces the following; a pending write in the output register at reset is discarded, and busy bits are not preserved:
  - rf_write = 0, rf_rd = 0, rf_writedata = 0
  - busy = all 0, so hazard = 0 once rs1/rs2 are settled
  - conflict_count = 0
  - last_conflict_winner = MEM
- alu_ready and mem_ready are 0 while reset = 0, regardless of the valid inputs.
- First edge after reset deasserts: normal operation.

## Test plan
- **Lone ALU write.** alu_valid=1, alu_rd=3, alu_data=16'h1234 in cycle 0 → alu_ready=1 in cycle 0; rf_write=1, rf_rd=3, rf_writedata=16'h1234 in cycle 1; rf_write=0 in cycle 2.
- **Conflict alternation.** Both valid for 4 cycles (alu_rd=1, mem_rd=2) from reset → grant order ALU, MEM, ALU, MEM; conflict_count=4.
- **r0 drop.** mem_valid=1, mem_rd=0, mem_data=16'hFFFF → mem_ready=1; rf_write stays 0; no busy bit changes.
- **Hazard lifecycle.** issue_valid=1, issue_rd=5 in cycle 0; rs1=5 from cycle 1 → hazard=1. mem write to r5 granted in cycle 3 → rf_write in cycle 4, hazard=0 in cycle 5. rs2=0 never raises hazard.
- **Set/clear collision.** rf_write to r7 and issue_valid with issue_rd=7 on the same edge → busy[7] remains 1 and hazard stays 1 for rs1=7.
- **Reset mid-operation.** Assert reset=0 asynchronously while rf_write=1 and busy[4]=1, between clock edges → rf_write=0, hazard=0, conflict_count=0 immediately. After release, the first conflict grants ALU.
